// File: rtl/hier_node_sequencer.sv
// Hierarchy node: fans a start out to NUM_CHILD children (broadcast or sequential) and reports one done pulse.
// Define HIER_TIMEOUT_EN to build the per-child timeout counter, err_o and to_mask_o logic.
module hier_node_sequencer #(
  parameter int NUM_CHILD = 5,
  parameter int TIMEOUT   = 200,
  parameter int TO_W      = 8,
  parameter int IDX_W     = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [NUM_CHILD-1:0] child_done_i,
  output logic [NUM_CHILD-1:0] child_start_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [NUM_CHILD-1:0] to_mask_o,
  output logic [IDX_W-1:0]     active_idx_o
);

  typedef enum logic [2:0] {
    IDLE,
    BCAST_WAIT,
    SEQ_ISSUE,
    SEQ_WAIT,
    FINISH
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHILD - 1);

  state_t               state;
  logic [NUM_CHILD-1:0] pend;
  logic [NUM_CHILD-1:0] pend_next;
  logic                 idx_done;
  logic                 to_fire;

  always_comb begin
    pend_next = pend & ~child_done_i;
    idx_done  = child_done_i[active_idx_o];
  end

`ifdef HIER_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            wait_cycle;

  // The broadcast issue cycle is the one with child_start_o still high; it is not a wait cycle.
  assign wait_cycle = (state == SEQ_WAIT) || ((state == BCAST_WAIT) && (child_start_o == '0));
  assign to_fire    = wait_cycle && (to_cnt == TO_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (((state == IDLE) && start_i) || (state == SEQ_ISSUE)) begin
      to_cnt <= TO_W'(TIMEOUT);
    end else if (wait_cycle && (to_cnt != '0)) begin
      to_cnt <= to_cnt - TO_W'(1);
    end
  end
`else
  logic unused_cfg;

  assign to_fire    = 1'b0;
  assign err_o      = 1'b0;
  assign to_mask_o  = '0;
  assign unused_cfg = ^{TIMEOUT, TO_W};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pend          <= '0;
      child_start_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      active_idx_o  <= '0;
`ifdef HIER_TIMEOUT_EN
      err_o         <= 1'b0;
      to_mask_o     <= '0;
`endif
    end else begin
      child_start_o <= '0;
      done_o        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            busy_o       <= 1'b1;
            active_idx_o <= '0;
            pend         <= '0;
`ifdef HIER_TIMEOUT_EN
            err_o        <= 1'b0;
            to_mask_o    <= '0;
`endif
            if (mode_i) begin
              state         <= SEQ_ISSUE;
              child_start_o <= NUM_CHILD'(1);
            end else begin
              state         <= BCAST_WAIT;
              child_start_o <= '1;
              pend          <= '1;
            end
          end
        end
        BCAST_WAIT: begin
          pend <= pend_next;
          if (pend_next == '0) begin
            state  <= FINISH;
            done_o <= 1'b1;
          end else if (to_fire) begin
`ifdef HIER_TIMEOUT_EN
            to_mask_o <= to_mask_o | pend_next;
            err_o     <= 1'b1;
`endif
            state     <= FINISH;
            done_o    <= 1'b1;
          end
        end
        SEQ_ISSUE: state <= SEQ_WAIT;
        SEQ_WAIT: begin
          if (idx_done || to_fire) begin
`ifdef HIER_TIMEOUT_EN
            if (!idx_done) begin
              to_mask_o[active_idx_o] <= 1'b1;
              err_o                   <= 1'b1;
            end
`endif
            if (active_idx_o == LAST_IDX) begin
              state        <= FINISH;
              done_o       <= 1'b1;
              active_idx_o <= '0;
            end else begin
              state         <= SEQ_ISSUE;
              active_idx_o  <= active_idx_o + IDX_W'(1);
              child_start_o <= NUM_CHILD'(1) << (active_idx_o + IDX_W'(1));
            end
          end
        end
        FINISH: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hier_node_sequencer.sv
// Scoreboard bench for hier_node_sequencer: child models answer starts after programmed delays;
// expected start pulses and completions are queued at stimulus time and popped on DUT output.
`timescale 1ns/1ps
module tb_hier_node_sequencer;

  localparam int NC = 5;
  localparam int TO = 10;
  localparam int IW = 3;
`ifdef HIER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          start_i = 1'b0;
  logic          mode_i  = 1'b0;
  logic [NC-1:0] child_done_i;
  logic [NC-1:0] child_start_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [NC-1:0] to_mask_o;
  logic [IW-1:0] active_idx_o;

  hier_node_sequencer #(
    .NUM_CHILD(NC),
    .TIMEOUT  (TO),
    .TO_W     (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .child_done_i (child_done_i),
    .child_start_o(child_start_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .to_mask_o    (to_mask_o),
    .active_idx_o (active_idx_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [NC-1:0] pat;
    logic [IW-1:0] idx;
  } start_exp_t;

  typedef struct {
    int            cyc;
    logic          err;
    logic [NC-1:0] mask;
  } done_exp_t;

  start_exp_t    start_q[$];
  done_exp_t     done_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            ncyc     = 0;
  int            delay[NC];
  int            cnt[NC];
  logic [NC-1:0] lvl   = '0;
  logic [NC-1:0] pulse = '0;

  assign child_done_i = pulse | lvl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Child models (delay 0 = silent) and output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    start_exp_t se;
    done_exp_t  de;
    ncyc++;
    for (int i = 0; i < NC; i++) begin
      pulse[i] = 1'b0;
      if (!rst_n) cnt[i] = 0;
      else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) pulse[i] = 1'b1;
      end
      if (rst_n && child_start_o[i] && delay[i] > 0) cnt[i] = delay[i];
    end
    if (rst_n && child_start_o != '0) begin
      if (start_q.size() == 0) check("start_unexpected", 32'(child_start_o), 32'd0);
      else begin
        se = start_q.pop_front();
        check("start_cycle", ncyc, se.cyc);
        check("start_pattern", 32'(child_start_o), 32'(se.pat));
        check("active_idx", 32'(active_idx_o), 32'(se.idx));
      end
    end
    if (rst_n && done_o) begin
      if (done_q.size() == 0) check("done_unexpected", 32'(done_o), 32'd0);
      else begin
        de = done_q.pop_front();
        check("done_cycle", ncyc, de.cyc);
        check("done_err", 32'(err_o), 32'(de.err));
        check("done_to_mask", 32'(to_mask_o), 32'(de.mask));
        check("done_busy", 32'(busy_o), 32'd1);
      end
    end
  end

  task automatic run(input bit seq, input int d[NC], input logic [NC-1:0] lv, input bit hold);
    int            s;
    int            t;
    int            mx;
    int            eff;
    logic [NC-1:0] mask;
    @(posedge clk); #1;
    for (int i = 0; i < NC; i++) delay[i] = d[i];
    lvl     = lv;
    mode_i  = seq;
    start_i = 1'b1;
    s       = ncyc + 1;
    t       = s + 1;
    mx      = 0;
    mask    = '0;
    for (int i = 0; i < NC; i++) begin
      if (lv[i]) eff = 0;
      else if (TO_EN && (d[i] == 0 || d[i] > TO)) begin
        eff     = TO;
        mask[i] = 1'b1;
      end else eff = d[i];
      if (seq) begin
        start_q.push_back('{t, NC'(1) << i, IW'(i)});
        t += eff + 1;
      end else if (eff > mx) mx = eff;
    end
    if (!seq) start_q.push_back('{s + 1, {NC{1'b1}}, '0});
    if (!hold) done_q.push_back('{seq ? t : s + 2 + mx, mask != '0, mask});
    @(posedge clk); #1;
    check("accept_busy", 32'(busy_o), 32'd1);
    check("accept_err_clear", 32'(err_o), 32'd0);
    check("accept_mask_clear", 32'(to_mask_o), 32'd0);
    if (!hold) start_i = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while ((start_q.size() != 0 || done_q.size() != 0) && k < 400) begin
      @(posedge clk);
      k++;
    end
    check("completion_in_budget", 32'(k < 400), 32'd1);
    start_q.delete();
    done_q.delete();
    #1;
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_done", 32'(done_o), 32'd0);
    lvl = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NC; i++) begin
      delay[i] = 0;
      cnt[i]   = 0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_child_start", 32'(child_start_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_to_mask", 32'(to_mask_o), 32'd0);
    check("rst_active_idx", 32'(active_idx_o), 32'd0);
    #2 rst_n = 1'b1;

    run(1'b0, '{1, 3, 2, 7, 4}, '0, 1'b0); wait_done();
    run(1'b1, '{1, 1, 1, 1, 1}, '0, 1'b0); wait_done();
    run(1'b1, '{2, 1, 3, 1, 2}, '0, 1'b0); wait_done();
    run(1'b0, '{1, 1, 1, 1, 1}, 5'h1F, 1'b0); wait_done();

    // Held start with child 1 silent, then asynchronous reset in its wait phase.
    run(1'b1, '{1, 0, 1, 1, 1}, '0, 1'b1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_child_start", 32'(child_start_o), 32'd0);
    check("midrun_rst_busy", 32'(busy_o), 32'd0);
    check("midrun_rst_done", 32'(done_o), 32'd0);
    check("midrun_rst_err", 32'(err_o), 32'd0);
    check("midrun_rst_to_mask", 32'(to_mask_o), 32'd0);
    check("midrun_rst_active_idx", 32'(active_idx_o), 32'd0);
    check("midrun_starts_left", start_q.size(), 32'd3);
    start_q.delete();
    done_q.delete();
    start_i = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    run(1'b0, '{2, 2, 2, 2, 2}, '0, 1'b0); wait_done();

`ifdef HIER_TIMEOUT_EN
    run(1'b1, '{1, 1, 0, 1, 1}, '0, 1'b0); wait_done();
    check("err_sticky_seq", 32'(err_o), 32'd1);
    check("mask_sticky_seq", 32'(to_mask_o), 32'h04);
    run(1'b0, '{1, 0, 3, 2, 0}, '0, 1'b0); wait_done();
    check("err_sticky_bcast", 32'(err_o), 32'd1);
    run(1'b1, '{1, 1, 10, 1, 1}, '0, 1'b0); wait_done();
    check("same_cycle_no_err", 32'(err_o), 32'd0);
    run(1'b0, '{10, 11, 1, 1, 1}, '0, 1'b0); wait_done();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
